// File: rtl/adc124s051_spi_responder.sv
// ----------------------------------------------------------------------------
// adc124s051_spi_responder: emulates the ADC124S051 4-channel 12-bit ADC on SPI
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adc124s051_spi_responder #(
  parameter int LEAD_ZEROS = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [11:0] iCh0,
  input  logic [11:0] iCh1,
  input  logic [11:0] iCh2,
  input  logic [11:0] iCh3,
  input  logic        iCS_n,
  input  logic        iSCLK,
  input  logic        iMOSI,
  output logic        oMISO,
  output logic        oMISO_oe,
  output logic [1:0]  oCh_sel,
  output logic        oFrame_done,
  output logic        oFrame_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] WAIT_CS = 2'd2;

  localparam logic [4:0] FIRST_BIT = 5'(LEAD_ZEROS + 1);
  localparam logic [4:0] LAST_BIT  = 5'(LEAD_ZEROS + 12);

  logic [1:0]  state;
  logic        cs_meta, cs_sync, cs_prev;
  logic        sclk_meta, sclk_sync, sclk_prev;
  logic        mosi_meta, mosi_sync;
  logic [11:0] shift_reg;
  logic [4:0]  fall_cnt, rise_cnt;
  logic [1:0]  addr_next;
  logic [11:0] ch_data;

  logic cs_fall, cs_rise, sclk_fall, sclk_rise;
  logic [4:0] fall_next, rise_next;

  assign cs_fall   = cs_prev & ~cs_sync;
  assign cs_rise   = ~cs_prev & cs_sync;
  assign sclk_fall = sclk_prev & ~sclk_sync;
  assign sclk_rise = ~sclk_prev & sclk_sync;
  assign fall_next = fall_cnt + 5'd1;
  assign rise_next = rise_cnt + 5'd1;

  always_comb begin
    ch_data = iCh0;
    case (oCh_sel)
      2'd0:    ch_data = iCh0;
      2'd1:    ch_data = iCh1;
      2'd2:    ch_data = iCh2;
      default: ch_data = iCh3;
    endcase
  end

  // CS chain resets low so a frame needs a fresh high-to-low after reset
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      cs_prev   <= 1'b0;
      sclk_meta <= 1'b1;
      sclk_sync <= 1'b1;
      sclk_prev <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= iCS_n;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      sclk_meta <= iSCLK;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= iMOSI;
      mosi_sync <= mosi_meta;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= IDLE;
      shift_reg   <= 12'd0;
      fall_cnt    <= 5'd0;
      rise_cnt    <= 5'd0;
      addr_next   <= 2'd0;
      oMISO       <= 1'b0;
      oMISO_oe    <= 1'b0;
      oCh_sel     <= 2'd0;
      oFrame_done <= 1'b0;
      oFrame_err  <= 1'b0;
    end else begin
      oFrame_done <= 1'b0;
      oFrame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift_reg <= ch_data;
            fall_cnt  <= 5'd0;
            rise_cnt  <= 5'd0;
            addr_next <= 2'd0;
            oMISO     <= 1'b0;
            oMISO_oe  <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // A CS rise outranks any SCLK edge seen in the same cycle
          if (cs_rise) begin
            oFrame_err <= 1'b1;
            oMISO      <= 1'b0;
            oMISO_oe   <= 1'b0;
            state      <= IDLE;
          end else if (sclk_fall) begin
            fall_cnt <= fall_next;
            if (fall_next >= FIRST_BIT && fall_next <= LAST_BIT) begin
              oMISO     <= shift_reg[11];
              shift_reg <= {shift_reg[10:0], 1'b0};
            end else begin
              oMISO <= 1'b0;
            end
          end else if (sclk_rise) begin
            rise_cnt <= rise_next;
            if (rise_next == 5'd4) addr_next[1] <= mosi_sync;
            if (rise_next == 5'd5) addr_next[0] <= mosi_sync;
            if (rise_next == 5'd16) begin
              oCh_sel     <= addr_next;
              oFrame_done <= 1'b1;
              oMISO       <= 1'b0;
              state       <= WAIT_CS;
            end
          end
        end
        WAIT_CS: begin
          if (cs_rise) begin
            oMISO    <= 1'b0;
            oMISO_oe <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc124s051_spi_responder.sv
// ----------------------------------------------------------------------------
// tb_adc124s051_spi_responder: directed frames with a scoreboard on frame pulses
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_adc124s051_spi_responder;

  logic        clk;
  logic        rst_n;
  logic [11:0] ch0, ch1, ch2, ch3;
  logic        cs_n, sclk, mosi;
  logic        miso, miso_oe, frame_done, frame_err;
  logic [1:0]  ch_sel;

  typedef struct {
    bit         is_err;
    logic [1:0] sel;
    logic [11:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          passed = 0;
  int          total  = 0;
  logic [11:0] rx_word;
  int          snap_fall = 0;
  logic [11:0] snap_val  = 12'h000;

  adc124s051_spi_responder #(.LEAD_ZEROS(4)) dut (
    .iClk        (clk),
    .iRst_n      (rst_n),
    .iCh0        (ch0),
    .iCh1        (ch1),
    .iCh2        (ch2),
    .iCh3        (ch3),
    .iCS_n       (cs_n),
    .iSCLK       (sclk),
    .iMOSI       (mosi),
    .oMISO       (miso),
    .oMISO_oe    (miso_oe),
    .oCh_sel     (ch_sel),
    .oFrame_done (frame_done),
    .oFrame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: pins change on negedge, MISO sampled 5 cycles after each SCLK fall
  task automatic spi_frame(input logic [1:0] addr, input int rises, input int extra,
                           input bit timing, input logic [11:0] exp_word, input int cs_high);
    logic exp_prev, exp_now;
    exp_prev = 1'b0;
    rx_word  = 12'h000;
    cs_n = 1'b0;
    mosi = 1'b0;
    wait_clk(2); if (timing) check("oe_before_3clk", 32'(miso_oe), 32'd0);
    wait_clk(1); if (timing) check("oe_at_3clk", 32'(miso_oe), 32'd1);
    wait_clk(5);
    for (int n = 1; n <= rises; n++) begin
      sclk = 1'b0;
      mosi = (n == 4) ? addr[1] : (n == 5) ? addr[0] : 1'b0;
      exp_now = (n >= 5 && n <= 16) ? exp_word[16 - n] : 1'b0;
      wait_clk(2); if (timing) check($sformatf("miso_hold_fall%0d", n), 32'(miso), 32'(exp_prev));
      wait_clk(1); if (timing) check($sformatf("miso_fall%0d", n), 32'(miso), 32'(exp_now));
      wait_clk(2);
      if (n >= 5) rx_word = {rx_word[10:0], miso};
      if (n == snap_fall) ch1 = snap_val;
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(10);
      exp_prev = exp_now;
    end
    for (int k = 0; k < extra; k++) begin
      sclk = 1'b0; wait_clk(10);
      sclk = 1'b1; wait_clk(10);
    end
    if (timing) check("miso_wait_cs", 32'(miso), 32'd0);
    cs_n = 1'b1;
    wait_clk(cs_high);
  endtask

  task automatic expect_frame(input bit is_err, input logic [1:0] sel, input logic [11:0] data);
    exp_t e;
    e.is_err = is_err;
    e.sel    = sel;
    e.data   = data;
    sbq.push_back(e);
  endtask

  // Monitor: every status pulse consumes one scoreboard entry
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (frame_done || frame_err)) begin
        check("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b expected none (t=%0t)",
                   frame_done, frame_err, $time);
        end else begin
          automatic exp_t e = sbq.pop_front();
          check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
          check("ch_sel_at_pulse", 32'(ch_sel), 32'(e.sel));
          if (!e.is_err) check("rx_data", 32'(rx_word), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit activity;
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b1;
    mosi  = 1'b0;
    ch0 = 12'h123; ch1 = 12'h0F0; ch2 = 12'hA5C; ch3 = 12'h3C3;
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_ch_sel", 32'(ch_sel), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    // Address pipelining
    expect_frame(0, 2'd2, 12'h123); spi_frame(2'd2, 16, 0, 0, 12'h123, 10);
    check("sel_after_f1", 32'(ch_sel), 32'd2);
    expect_frame(0, 2'd3, 12'hA5C); spi_frame(2'd3, 16, 0, 0, 12'hA5C, 10);
    check("sel_after_f2", 32'(ch_sel), 32'd3);
    expect_frame(0, 2'd0, 12'h3C3); spi_frame(2'd0, 16, 0, 0, 12'h3C3, 10);

    // MISO bit pattern with exact 3-cycle latency
    ch0 = 12'hFFF;
    expect_frame(0, 2'd1, 12'hFFF); spi_frame(2'd1, 16, 0, 1, 12'hFFF, 10);

    // Snapshot: channel 1 changes mid-frame
    snap_fall = 6; snap_val = 12'hF0F;
    expect_frame(0, 2'd2, 12'h0F0); spi_frame(2'd2, 16, 0, 0, 12'h0F0, 10);
    snap_fall = 0;

    // Abort after 8 rises
    expect_frame(1, 2'd2, 12'h000); spi_frame(2'd3, 8, 0, 0, 12'h000, 10);
    check("sel_after_abort", 32'(ch_sel), 32'd2);
    expect_frame(0, 2'd0, 12'hA5C); spi_frame(2'd0, 16, 0, 0, 12'hA5C, 10);

    // Extra edges and back-to-back frames
    expect_frame(0, 2'd1, 12'hFFF); spi_frame(2'd1, 16, 4, 0, 12'hFFF, 3);
    expect_frame(0, 2'd3, 12'hF0F); spi_frame(2'd3, 16, 0, 0, 12'hF0F, 10);
    check("sel_after_b2b", 32'(ch_sel), 32'd3);

    // Reset mid-frame with CS held low
    cs_n = 1'b0;
    wait_clk(8);
    for (int n = 1; n <= 7; n++) begin
      sclk = 1'b0;
      mosi = (n == 4) ? 1'b1 : 1'b0;
      wait_clk(10);
      if (n < 7) begin sclk = 1'b1; wait_clk(10); end
    end
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    activity = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sclk = ~sclk;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (miso_oe || miso) activity = 1'b1;
      end
    end
    sclk = 1'b1;
    check("rst_mid_no_activity", 32'(activity), 32'd0);
    check("rst_mid_ch_sel", 32'(ch_sel), 32'd0);
    cs_n = 1'b1;
    wait_clk(10);
    ch0 = 12'h5A6;
    expect_frame(0, 2'd2, 12'h5A6); spi_frame(2'd2, 16, 0, 0, 12'h5A6, 10);

    wait_clk(20);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
